// File: rtl/incdec_pkg.sv
// incdec_pkg: shared types and reference functions for the inc/dec result checker.
//   u4      : 4-bit wrapping operand type
//   rec12_t : one 12-bit result record {x, y, a}
//   state_t : checker run/halt state
//   exp_r1..exp_r4 : expected record for each operator case, given operands w1, w2
//   REC_W   : record width in bits
package incdec_pkg;

  localparam int REC_W = 12;

  typedef logic [3:0] u4;

  typedef struct packed {
    u4 x;
    u4 y;
    u4 a;
  } rec12_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // post-increment case: operands incremented, a = xor of the original operands
  function automatic rec12_t exp_r1(input u4 w1, input u4 w2);
    rec12_t r;
    r.x = w1 + 4'd1;
    r.y = w2 + 4'd1;
    r.a = w1 ^ w2;
    return r;
  endfunction

  // post-decrement case: operands decremented, a = sum of the original operands
  function automatic rec12_t exp_r2(input u4 w1, input u4 w2);
    rec12_t r;
    r.x = w1 - 4'd1;
    r.y = w2 - 4'd1;
    r.a = w1 + w2;
    return r;
  endfunction

  // pre-increment case: a is computed from the already-incremented operands
  function automatic rec12_t exp_r3(input u4 w1, input u4 w2);
    rec12_t r;
    r.x = w1 + 4'd1;
    r.y = w2 + 4'd1;
    r.a = r.x | r.y;
    return r;
  endfunction

  // pre-decrement case: a is computed from the already-decremented operands
  function automatic rec12_t exp_r4(input u4 w1, input u4 w2);
    rec12_t r;
    r.x = w1 - 4'd1;
    r.y = w2 - 4'd1;
    r.a = r.x & r.y;
    return r;
  endfunction

endpackage

// File: rtl/incdec_skid2.sv
// incdec_skid2: two-entry FIFO used as the checker's input skid buffer.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (empties the buffer)
//   push/push_data : write one entry (ignored when full unless popping the same cycle)
//   pop            : remove the head entry (ignored when empty)
//   head_data      : current head entry (valid when !empty)
//   empty, full    : occupancy flags, derived from registered state only
module incdec_skid2 #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  // A push into a full buffer is only safe when the head leaves in the same cycle;
  // the write then lands in the slot being vacated.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign head_data = mem_reg[rd_ptr_reg];

  // Payload storage carries no reset; occupancy tracking alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop_ok) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/incdec_check.sv
// incdec_check: checks packed result words from the nibble increment/decrement stage.
// Each 48-bit input word holds records {r4,r3,r2,r1}; the operands are recovered from
// r1, all four records are recomputed, and a per-record mismatch mask is produced.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     : input word stream (2-entry skid buffer behind it)
//   res_valid/res_ready           : result stream handshake
//   res_mask                      : bit k set = record r(k+1) mismatched
//   res_w1/res_w2                 : operands recovered from r1
//   pass_count/fail_count         : saturating word counters, updated on result load
//   halted                        : sticky halt after first failure (STOP_ON_ERR=1 only)
// Optional macro INCDEC_CHECK_TRACE_EN adds first_fail_data/first_fail_valid, which
// capture the first failing input word after reset.
module incdec_check
  import incdec_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*REC_W-1:0]   in_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [3:0]           res_mask,
  output logic [3:0]           res_w1,
  output logic [3:0]           res_w2,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic                 halted
`ifdef INCDEC_CHECK_TRACE_EN
  ,
  output logic [4*REC_W-1:0]   first_fail_data,
  output logic                 first_fail_valid
`endif
);

  localparam int              DATA_W  = 4 * REC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_reg;
  state_t            state_next;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              load;
  logic [DATA_W-1:0] head_data;
  rec12_t            rec     [4];
  rec12_t            exp_rec [4];
  u4                 w1;
  u4                 w2;
  logic [3:0]        mask;

  // Depends only on registered state, so res_ready never reaches in_ready combinationally.
  assign in_ready = !fifo_full && (state_reg == RUN);
  assign push     = in_valid && in_ready;
  // The output register refills whenever it is empty or being consumed this cycle.
  assign load     = !fifo_empty && (!res_valid || res_ready);
  assign halted   = (state_reg == HALT);

  incdec_skid2 #(
    .W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (load),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Split the head word into records; rec[0] is r1.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_split
      assign rec[gi] = head_data[gi*REC_W +: REC_W];
    end
  endgenerate

  // r1 carries the post-incremented operands, so the originals are one below.
  assign w1 = rec[0].x - 4'd1;
  assign w2 = rec[0].y - 4'd1;

  assign exp_rec[0] = exp_r1(w1, w2);
  assign exp_rec[1] = exp_r2(w1, w2);
  assign exp_rec[2] = exp_r3(w1, w2);
  assign exp_rec[3] = exp_r4(w1, w2);

  // r1's x/y fields define w1/w2 and so always agree with themselves; only its a field
  // carries independent information.
  assign mask[0] = (rec[0].a != exp_rec[0].a);

  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_cmp
      assign mask[gi] = (rec[gi] != exp_rec[gi]);
    end
  endgenerate

  // Result register: held while res_valid && !res_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_mask  <= 4'd0;
      res_w1    <= 4'd0;
      res_w2    <= 4'd0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_mask  <= mask;
      res_w1    <= w1;
      res_w2    <= w2;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Counters advance when a word enters the result register and stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (load) begin
      if (mask == 4'd0) begin
        if (pass_count != CNT_MAX) begin
          pass_count <= pass_count + CNT_W'(1);
        end
      end else begin
        if (fail_count != CNT_MAX) begin
          fail_count <= fail_count + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // HALT is left only through reset; words already buffered keep draining.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RUN: begin
        if ((STOP_ON_ERR != 0) && load && (mask != 4'd0)) begin
          state_next = HALT;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

`ifdef INCDEC_CHECK_TRACE_EN
  // The failing word is still at the FIFO head when it loads, so capture it from there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_data  <= '0;
      first_fail_valid <= 1'b0;
    end else if (load && (mask != 4'd0) && !first_fail_valid) begin
      first_fail_data  <= head_data;
      first_fail_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_incdec_check.sv
// tb_incdec_check: self-checking bench for incdec_check.
// Three instances: default (m_), STOP_ON_ERR=1 (h_), CNT_W=2 (s_).
module tb_incdec_check;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_in_valid = 1'b0, m_in_ready, m_res_valid, m_res_ready = 1'b1, m_halted;
  logic [47:0] m_in_data = '0;
  logic [3:0]  m_mask, m_w1, m_w2;
  logic [15:0] m_pass, m_fail;

  logic        h_in_valid = 1'b0, h_in_ready, h_res_valid, h_res_ready = 1'b1, h_halted;
  logic [47:0] h_in_data = '0;
  logic [3:0]  h_mask, h_w1, h_w2;
  logic [15:0] h_pass, h_fail;

  logic        s_in_valid = 1'b0, s_in_ready, s_res_valid, s_res_ready = 1'b1, s_halted;
  logic [47:0] s_in_data = '0;
  logic [3:0]  s_mask, s_w1, s_w2;
  logic [1:0]  s_pass, s_fail;

`ifdef INCDEC_CHECK_TRACE_EN
  logic [47:0] m_ffd, h_ffd, s_ffd;
  logic        m_ffv, h_ffv, s_ffv;
`endif

  incdec_check u_main (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .res_valid(m_res_valid), .res_ready(m_res_ready), .res_mask(m_mask), .res_w1(m_w1),
    .res_w2(m_w2), .pass_count(m_pass), .fail_count(m_fail), .halted(m_halted)
`ifdef INCDEC_CHECK_TRACE_EN
    , .first_fail_data(m_ffd), .first_fail_valid(m_ffv)
`endif
  );

  incdec_check #(.CNT_W(16), .STOP_ON_ERR(1)) u_halt (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .res_valid(h_res_valid), .res_ready(h_res_ready), .res_mask(h_mask), .res_w1(h_w1),
    .res_w2(h_w2), .pass_count(h_pass), .fail_count(h_fail), .halted(h_halted)
`ifdef INCDEC_CHECK_TRACE_EN
    , .first_fail_data(h_ffd), .first_fail_valid(h_ffv)
`endif
  );

  incdec_check #(.CNT_W(2), .STOP_ON_ERR(0)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .res_mask(s_mask), .res_w1(s_w1),
    .res_w2(s_w2), .pass_count(s_pass), .fail_count(s_fail), .halted(s_halted)
`ifdef INCDEC_CHECK_TRACE_EN
    , .first_fail_data(s_ffd), .first_fail_valid(s_ffv)
`endif
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (operator rules, plain integer arithmetic) ----------
  function automatic logic [11:0] rec(input int x, input int y, input int a);
    return 12'(x * 256 + y * 16 + a);
  endfunction

  function automatic logic [47:0] make_word(input int w1, input int w2);
    int i1, i2, d1, d2;
    i1 = (w1 + 1) % 16;  i2 = (w2 + 1) % 16;
    d1 = (w1 + 15) % 16; d2 = (w2 + 15) % 16;
    return {rec(d1, d2, d1 & d2), rec(i1, i2, i1 | i2), rec(d1, d2, (w1 + w2) % 16),
            rec(i1, i2, w1 ^ w2)};
  endfunction

  // returns {mask, w1, w2}
  function automatic logic [11:0] model(input logic [47:0] d);
    int w1, w2;
    logic [47:0] good;
    logic [3:0]  m;
    w1   = (int'(d[11:8]) + 15) % 16;
    w2   = (int'(d[7:4]) + 15) % 16;
    good = make_word(w1, w2);
    m[0] = (d[3:0] != good[3:0]);
    m[1] = (d[23:12] != good[23:12]);
    m[2] = (d[35:24] != good[35:24]);
    m[3] = (d[47:36] != good[47:36]);
    return {m, 4'(w1), 4'(w2)};
  endfunction

  function automatic logic [47:0] gen_word();
    logic [47:0] w;
    logic [63:0] r;
    int sel, k;
    w   = make_word($urandom_range(0, 15), $urandom_range(0, 15));
    sel = $urandom_range(0, 9);
    k   = $urandom_range(0, 3);
    if (sel < 3) begin
      w = w ^ (48'($urandom_range(1, 4095)) << (12 * k));
    end else if (sel == 3) begin
      r = {$urandom, $urandom};
      w = r[47:0];
    end
    return w;
  endfunction

  // ---------------- scoreboard for the default instance ----------------
  logic [47:0] exp_q[$];
  int          exp_pass = 0, exp_fail = 0;
  logic [47:0] first_fail_word = '0;
  bit          have_first_fail = 1'b0;
  logic [11:0] mon_e, mon_f;
  bit          rand_bp = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_res_valid) begin
        if (exp_q.size() == 0) begin
          check("res_without_input", 64'(m_res_valid), 64'(0));
        end else begin
          mon_e = model(exp_q[0]);
          check("res_mask", 64'(m_mask), 64'(mon_e[11:8]));
          check("res_w1", 64'(m_w1), 64'(mon_e[7:4]));
          check("res_w2", 64'(m_w2), 64'(mon_e[3:0]));
          if (m_res_ready) begin
            $display("txn data=%012h mask=%b w1=%0h w2=%0h", exp_q[0], m_mask, m_w1, m_w2);
            if (mon_e[11:8] == 4'd0) exp_pass++;
            else exp_fail++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(m_in_data);
        mon_f = model(m_in_data);
        if (!have_first_fail && mon_f[11:8] != 4'd0) begin
          have_first_fail = 1'b1;
          first_fail_word = m_in_data;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_bp) m_res_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(input int which, input logic [47:0] d, input int budget, output bit acc);
    acc = 1'b0;
    case (which)
      0: begin m_in_valid = 1'b1; m_in_data = d; end
      1: begin h_in_valid = 1'b1; h_in_data = d; end
      default: begin s_in_valid = 1'b1; s_in_data = d; end
    endcase
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      case (which)
        0: acc = m_in_valid && m_in_ready;
        1: acc = h_in_valid && h_in_ready;
        default: acc = s_in_valid && s_in_ready;
      endcase
      @(posedge clk); #1;
      if (rand_bp) m_res_ready = ($urandom_range(0, 3) != 0);
    end
    m_in_valid = 1'b0;
    h_in_valid = 1'b0;
    s_in_valid = 1'b0;
  endtask

  initial begin
    bit          acc;
    logic [47:0] w;
    logic [11:0] e;
    int          h_exp_pass, h_exp_fail, n_sat;
    h_exp_pass = 0;
    h_exp_fail = 0;

    // reset state
    #12;
    check("rst_in_ready", 64'(m_in_ready), 64'(1));
    check("rst_res_valid", 64'(m_res_valid), 64'(0));
    check("rst_mask", 64'(m_mask), 64'(0));
    check("rst_w1", 64'(m_w1), 64'(0));
    check("rst_w2", 64'(m_w2), 64'(0));
    check("rst_pass", 64'(m_pass), 64'(0));
    check("rst_fail", 64'(m_fail), 64'(0));
    check("rst_halted", 64'(m_halted), 64'(0));
`ifdef INCDEC_CHECK_TRACE_EN
    check("rst_ff_valid", 64'(m_ffv), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // golden word w1=3, w2=5, one cycle after acceptance
    send(0, 48'h240_466_248_466, 4, acc);
    check("golden_accept", 64'(acc), 64'(1));
    check("golden_lat0", 64'(m_res_valid), 64'(0));
    @(posedge clk); #1;
    check("golden_valid", 64'(m_res_valid), 64'(1));
    check("golden_mask", 64'(m_mask), 64'(0));
    check("golden_w1", 64'(m_w1), 64'(3));
    check("golden_w2", 64'(m_w2), 64'(5));
    check("golden_pass", 64'(m_pass), 64'(1));
    idle(2);

    // wrap case w1=F, w2=0, then r3.a flipped to 0
    send(0, 48'hEFE_011_EFF_01F, 4, acc);
    send(0, 48'hEFE_010_EFF_01F, 4, acc);
    @(posedge clk); #1;
    check("wrap_bad_mask", 64'(m_mask), 64'(4'b0100));
    check("wrap_pass", 64'(m_pass), 64'(2));
    check("wrap_fail", 64'(m_fail), 64'(1));
    idle(2);

    // backpressure: three words fill result register plus both buffer entries
    m_res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(0, make_word(i + 1, i + 8), 4, acc);
      check("bp_accept", 64'(acc), 64'(1));
    end
    check("bp_in_ready", 64'(m_in_ready), 64'(0));
    send(0, make_word(9, 9), 3, acc);
    check("bp_reject", 64'(acc), 64'(0));
    check("bp_held_w1", 64'(m_w1), 64'(1));
    m_res_ready = 1'b1;
    idle(6);
    check("bp_drain", 64'(exp_q.size()), 64'(0));
    check("bp_pass", 64'(m_pass), 64'(exp_pass));

    // STOP_ON_ERR=1: good, bad, good, then a word that must be refused
    send(1, make_word(1, 2), 4, acc);
    check("halt_acc0", 64'(acc), 64'(1));
    check("halt_pre", 64'(h_halted), 64'(0));
    if (acc) h_exp_pass++;
    send(1, make_word(4, 5) ^ 48'h0000_0000_0001, 4, acc);
    if (acc) h_exp_fail++;
    send(1, make_word(6, 7), 4, acc);
    if (acc) h_exp_pass++;
    send(1, make_word(8, 9), 6, acc);
    check("halt_refused", 64'(acc), 64'(0));
    check("halt_halted", 64'(h_halted), 64'(1));
    check("halt_in_ready", 64'(h_in_ready), 64'(0));
    idle(4);
    check("halt_pass", 64'(h_pass), 64'(h_exp_pass));
    check("halt_fail", 64'(h_fail), 64'(1));
    check("halt_fail_model", 64'(h_fail), 64'(h_exp_fail));

    // saturation with a 2-bit counter
    n_sat = 0;
    for (int i = 0; i < 5; i++) begin
      send(2, make_word(i, 15 - i), 4, acc);
      if (acc) n_sat++;
    end
    idle(4);
    check("sat_pass", 64'(s_pass), 64'((n_sat > 3) ? 3 : n_sat));
    check("sat_fail", 64'(s_fail), 64'(0));

    // randomized stream with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = gen_word();
      send(0, w, 50, acc);
      check("rand_accept", 64'(acc), 64'(1));
      idle($urandom_range(0, 2));
    end
    rand_bp = 1'b0;
    m_res_ready = 1'b1;
    idle(6);
    check("rand_drain", 64'(exp_q.size()), 64'(0));
    check("rand_pass", 64'(m_pass), 64'(exp_pass));
    check("rand_fail", 64'(m_fail), 64'(exp_fail));

`ifdef INCDEC_CHECK_TRACE_EN
    check("trace_valid", 64'(m_ffv), 64'(have_first_fail));
    check("trace_data", 64'(m_ffd), 64'(first_fail_word));
`endif

    // mid-stream asynchronous reset
    m_res_ready = 1'b0;
    send(0, make_word(2, 3), 4, acc);
    send(0, make_word(4, 6), 4, acc);
    #2 rst = 1'b1;
    #1;
    check("mrst_in_ready", 64'(m_in_ready), 64'(1));
    check("mrst_res_valid", 64'(m_res_valid), 64'(0));
    check("mrst_mask", 64'(m_mask), 64'(0));
    check("mrst_w1", 64'(m_w1), 64'(0));
    check("mrst_pass", 64'(m_pass), 64'(0));
    check("mrst_fail", 64'(m_fail), 64'(0));
    check("mrst_halted", 64'(h_halted), 64'(0));
    check("mrst_h_in_ready", 64'(h_in_ready), 64'(1));
    check("mrst_sat_pass", 64'(s_pass), 64'(0));
`ifdef INCDEC_CHECK_TRACE_EN
    check("mrst_ff_valid", 64'(m_ffv), 64'(0));
    check("mrst_ff_data", 64'(m_ffd), 64'(0));
`endif
    exp_q.delete();
    exp_pass = 0;
    exp_fail = 0;
    have_first_fail = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_res_ready = 1'b1;

    // one word after reset: counting restarts from zero
    w = make_word(10, 12);
    e = model(w);
    send(0, w, 4, acc);
    idle(3);
    check("post_rst_pass", 64'(m_pass), 64'(exp_pass));
    check("post_rst_w1", 64'(m_w1), 64'(e[7:4]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // absolute guard against a hung run
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
